// File: rtl/nonce_dispatch_multi.sv
// Multi-core nonce dispatcher: interleaves nonce slices across NUM_CORES hashers,
// realigns their pipelined results and queues golden nonces for the comm side.
module nonce_dispatch_multi #(
  parameter int          NUM_CORES    = 2,
  parameter int          PIPE_LATENCY = 253,
  parameter logic [31:0] MATCH_VALUE  = 32'hA41F32E7,
  parameter int          FIFO_DEPTH   = 8,
  // Width of the searched nonce space; values below 32 shrink the sweep.
  parameter int          NONCE_BITS   = 32
) (
  input  logic                      hash_clk,
  input  logic                      reset,
  input  logic                      new_work,
  input  logic [255:0]              work_midstate,
  input  logic [95:0]               work_data,
  output logic [255:0]              core_midstate,
  output logic [95:0]               core_data,
  output logic [32*NUM_CORES-1:0]   core_nonce,
  input  logic [32*NUM_CORES-1:0]   core_hash,
  output logic                      busy,
  output logic                      exhausted,
  output logic                      nonce_valid,
  output logic [31:0]               nonce_out,
  input  logic                      nonce_ready,
  output logic                      overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int L     = $clog2(NUM_CORES);
  localparam int W     = NONCE_BITS - L;
  localparam int WU_W  = (PIPE_LATENCY > 1) ? $clog2(PIPE_LATENCY) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [W-1:0]    B_MAX  = '1;
  localparam logic [WU_W-1:0] WU_MAX = WU_W'(PIPE_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [W-1:0]           b_q, b_d;
  logic [W-1:0]           cb_q, cb_d;
  logic [WU_W-1:0]        wu_q, wu_d;
  logic [NUM_CORES-1:0]   hit_q, hit_d;
  logic [W-1:0]           hit_base_q, hit_base_d;
  logic [255:0]           midstate_q, midstate_d;
  logic [95:0]            data_q, data_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic [31:0]            mem_q [FIFO_DEPTH];

  logic [31:0]            win_idx;
  logic [31:0]            wr_nonce;
  logic                   wr_en;
  logic                   multi_hit;
  logic                   fifo_full;
  logic                   push;
  logic                   pop;

  // Sequencer: new_work restarts the sweep from any state.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    b_d        = b_q;
    cb_d       = cb_q;
    wu_d       = wu_q;
    hit_d      = '0;
    hit_base_d = hit_base_q;
    midstate_d = midstate_q;
    data_d     = data_q;

    if (new_work) begin
      midstate_d = work_midstate;
      data_d     = work_data;
      b_d        = '0;
      cb_d       = '0;
      wu_d       = '0;
      state_d    = S_FILL;
    end else begin
      case (state_q)
        S_FILL: begin
          b_d  = b_q + W'(1);
          wu_d = wu_q + WU_W'(1);
          if (wu_q == WU_MAX) state_d = S_RUN;
        end
        S_RUN: begin
          for (int k = 0; k < NUM_CORES; k++)
            hit_d[k] = (core_hash[32*k +: 32] == MATCH_VALUE);
          hit_base_d = cb_q;
          cb_d       = cb_q + W'(1);
          if (b_q == B_MAX) state_d = S_DRAIN;
          else              b_d     = b_q + W'(1);
        end
        S_DRAIN: begin
          for (int k = 0; k < NUM_CORES; k++)
            hit_d[k] = (core_hash[32*k +: 32] == MATCH_VALUE);
          hit_base_d = cb_q;
          if (cb_q == B_MAX) state_d = S_DONE;
          else               cb_d    = cb_q + W'(1);
        end
        default: ;
      endcase
    end
  end

  // Lowest-numbered hitting core wins the single write slot.
  always_comb begin
    win_idx = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--)
      if (hit_q[k]) win_idx = 32'(k);
  end

  always_comb begin
    wr_en      = |hit_q;
    multi_hit  = |(hit_q & (hit_q - NUM_CORES'(1)));
    wr_nonce   = (32'(hit_base_q) << L) | win_idx;
    pop        = (count_q != '0) && nonce_ready;
    fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    push       = wr_en && (!fifo_full || pop);
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    overflow_d = overflow_q | (wr_en && fifo_full && !pop) | multi_hit;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      b_q        <= '0;
      cb_q       <= '0;
      wu_q       <= '0;
      hit_q      <= '0;
      hit_base_q <= '0;
      midstate_q <= '0;
      data_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      b_q        <= b_d;
      cb_q       <= cb_d;
      wu_q       <= wu_d;
      hit_q      <= hit_d;
      hit_base_q <= hit_base_d;
      midstate_q <= midstate_d;
      data_q     <= data_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: storage is not reset; the count gates visibility, so stale contents are never observed.
  always_ff @(posedge hash_clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_nonce;
  end

  always_comb begin
    for (int k = 0; k < NUM_CORES; k++)
      core_nonce[32*k +: 32] = (32'(b_q) << L) | 32'(k);
  end

  assign core_midstate = midstate_q;
  assign core_data     = data_q;
  assign busy          = (state_q == S_FILL) || (state_q == S_RUN) || (state_q == S_DRAIN);
  assign exhausted     = (state_q == S_DONE);
  assign nonce_valid   = (count_q != '0);
  assign nonce_out     = nonce_valid ? mem_q[rd_ptr_q] : '0;
  assign overflow      = overflow_q;
  assign fifo_count    = count_q;

endmodule
